// File: rtl/mem_arbiter_pkg.sv
// Shared types for the byte-wide RAM port arbiter: FSM state encodings,
// transfer length codes and bus widths.
package mem_arbiter_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;

  typedef logic [BYTE_W-1:0] byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IF_RD  = 2'd1,
    ARB_MEM_RD = 2'd2,
    ARB_MEM_WR = 2'd3
  } arb_state_e;

  // Length codes are "beats minus one".
  localparam logic [1:0] MEM_LEN_BYTE = 2'd0;
  localparam logic [1:0] MEM_LEN_HALF = 2'd1;
  localparam logic [1:0] MEM_LEN_WORD = 2'd3;

  // Code 2 has no meaning on the bus; it is promoted to a full word.
  function automatic logic [1:0] norm_len(input logic [1:0] len);
    logic [1:0] res;
    case (len)
      MEM_LEN_BYTE: res = MEM_LEN_BYTE;
      MEM_LEN_HALF: res = MEM_LEN_HALF;
      default:      res = MEM_LEN_WORD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_arbiter_rd_pipe.sv
// Tracks outstanding RAM read beats: a LAT-deep (valid, beat index) shift
// register whose tail says which assembly byte ram_din belongs to.
module mem_arbiter_rd_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush_i,
  input  logic       in_valid_i,
  input  logic [1:0] in_idx_i,
  output logic       out_valid_o,
  output logic [1:0] out_idx_o
);

  for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
    logic       valid_q;
    logic [1:0] idx_q;
    logic       valid_d;
    logic [1:0] idx_d;

    if (gi == 0) begin : g_head
      assign valid_d = in_valid_i;
      assign idx_d   = in_idx_i;
    end else begin : g_tail
      assign valid_d = g_stage[gi-1].valid_q;
      assign idx_d   = g_stage[gi-1].idx_q;
    end

    // A flush drops every beat still in flight so stale bytes never land.
    always_ff @(posedge clk) begin
      if (rst || flush_i) begin
        valid_q <= 1'b0;
        idx_q   <= 2'd0;
      end else begin
        valid_q <= valid_d;
        idx_q   <= idx_d;
      end
    end
  end

  assign out_valid_o = g_stage[LAT-1].valid_q;
  assign out_idx_o   = g_stage[LAT-1].idx_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the byte-wide RAM port between instruction fetch and load/store.
// Optional macro IF_FLUSH_EN adds the if_flush input that aborts a fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int RAM_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [WORD_W-1:0] if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_len,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_wdata,
  output logic [WORD_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_a,
  output logic [BYTE_W-1:0] ram_dout,
  output logic              ram_wr,
  input  logic [BYTE_W-1:0] ram_din,
`ifdef IF_FLUSH_EN
  input  logic              if_flush,
`endif
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ram_a_q, ram_a_d;
  byte_t             ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic [WORD_W-1:0] if_data_q, if_data_d;
  logic [WORD_W-1:0] mem_rdata_q, mem_rdata_d;
  logic              if_done_q, if_done_d;
  logic              mem_done_q, mem_done_d;
  logic [1:0]        beat_q, beat_d;
  logic              issuing_q, issuing_d;
  logic [1:0]        len_q, len_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] asm_q, asm_d;

  logic              flush_act;
  logic              pipe_in_valid;
  logic              pipe_valid;
  logic [1:0]        pipe_idx;
  logic [WORD_W-1:0] asm_cap;
  logic [1:0]        beat_nxt;

`ifdef IF_FLUSH_EN
  assign flush_act = if_flush && (state_q == ARB_IF_RD);
`else
  assign flush_act = 1'b0;
`endif

  assign pipe_in_valid = issuing_q &&
                         ((state_q == ARB_IF_RD) || (state_q == ARB_MEM_RD));
  assign beat_nxt      = beat_q + 2'd1;

  mem_arbiter_rd_pipe #(
    .LAT (RAM_RD_LAT)
  ) u_rd_pipe (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_act),
    .in_valid_i  (pipe_in_valid),
    .in_idx_i    (beat_q),
    .out_valid_o (pipe_valid),
    .out_idx_o   (pipe_idx)
  );

  always_comb begin
    asm_cap = asm_q;
    asm_cap[{pipe_idx, 3'b000} +: BYTE_W] = ram_din;
  end

  always_comb begin
    state_d     = state_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    if_done_d   = 1'b0;
    mem_done_d  = 1'b0;
    beat_d      = beat_q;
    issuing_d   = issuing_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;

    case (state_q)
      ARB_IDLE: begin
        // The done cycle is a bubble so the finished requester can drop req.
        if (!if_done_q && !mem_done_q) begin
          if (mem_req) begin
            len_d   = norm_len(mem_len);
            ram_a_d = mem_addr;
            beat_d  = 2'd0;
            asm_d   = '0;
            wdata_d = mem_wdata;
            if (mem_we) begin
              state_d    = ARB_MEM_WR;
              ram_wr_d   = 1'b1;
              ram_dout_d = mem_wdata[BYTE_W-1:0];
            end else begin
              state_d   = ARB_MEM_RD;
              issuing_d = 1'b1;
            end
          end else if (if_req) begin
            state_d   = ARB_IF_RD;
            len_d     = MEM_LEN_WORD;
            ram_a_d   = if_addr;
            beat_d    = 2'd0;
            asm_d     = '0;
            issuing_d = 1'b1;
          end
        end
      end

      ARB_IF_RD, ARB_MEM_RD: begin
        if (issuing_q) begin
          if (beat_q == len_q) begin
            issuing_d = 1'b0;
          end else begin
            beat_d  = beat_nxt;
            ram_a_d = ram_a_q + ADDR_W'(1);
          end
        end
        if (pipe_valid) begin
          asm_d = asm_cap;
          if (pipe_idx == len_q) begin
            state_d = ARB_IDLE;
            if (state_q == ARB_IF_RD) begin
              if_data_d = asm_cap;
              if_done_d = 1'b1;
            end else begin
              mem_rdata_d = asm_cap;
              mem_done_d  = 1'b1;
            end
          end
        end
        if (flush_act) begin
          state_d   = ARB_IDLE;
          issuing_d = 1'b0;
          if_data_d = if_data_q;
          if_done_d = 1'b0;
        end
      end

      ARB_MEM_WR: begin
        if (beat_q == len_q) begin
          state_d    = ARB_IDLE;
          mem_done_d = 1'b1;
        end else begin
          beat_d     = beat_nxt;
          ram_a_d    = ram_a_q + ADDR_W'(1);
          ram_wr_d   = 1'b1;
          ram_dout_d = wdata_q[{beat_nxt, 3'b000} +: BYTE_W];
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      ram_a_q     <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      beat_q      <= 2'd0;
      issuing_q   <= 1'b0;
      len_q       <= 2'd0;
      wdata_q     <= '0;
      asm_q       <= '0;
    end else begin
      state_q     <= state_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
      beat_q      <= beat_d;
      issuing_q   <= issuing_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
    end
  end

  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  assign ram_wr    = ram_wr_q;
  assign if_data   = if_data_q;
  assign mem_rdata = mem_rdata_q;
  assign if_done   = if_done_q;
  assign mem_done  = mem_done_q;

  assign stall_req_if  = if_req & ~if_done_q;
  assign stall_req_mem = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a one-cycle-latency byte RAM model.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_done;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_len;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din;
  logic        stall_req_if;
  logic        stall_req_mem;
`ifdef IF_FLUSH_EN
  logic        if_flush;
`endif

  int passes = 0;
  int total  = 0;

  logic [7:0]  ram [4096];
  logic [31:0] wword;

  mem_arbiter #(
    .ADDR_W     (32),
    .RAM_RD_LAT (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_data       (if_data),
    .if_done       (if_done),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_len       (mem_len),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_done      (mem_done),
    .ram_a         (ram_a),
    .ram_dout      (ram_dout),
    .ram_wr        (ram_wr),
    .ram_din       (ram_din),
`ifdef IF_FLUSH_EN
    .if_flush      (if_flush),
`endif
    .stall_req_if  (stall_req_if),
    .stall_req_mem (stall_req_mem)
  );

  always #5 clk = ~clk;

  // Read-only RAM model: data for the address seen at an edge appears after it.
  always @(posedge clk) ram_din <= ram[ram_a[11:0]];

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Full word fetch with the bus idle: done appears five edges after grant.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] exp, input string tag);
    if_req  = 1'b1;
    if_addr = addr;
    for (int m = 1; m <= 6; m++) begin
      tick();
      if (m <= 4) chk({tag, "_ram_a"}, ram_a, addr + 32'(m - 1));
      if (m == 5) chk({tag, "_early_done"}, {31'd0, if_done}, 32'd0);
    end
    chk({tag, "_done"}, {31'd0, if_done}, 32'd1);
    chk({tag, "_data"}, if_data, exp);
    chk({tag, "_stall_low"}, {31'd0, stall_req_if}, 32'd0);
    if_req = 1'b0;
    tick();
    chk({tag, "_done_pulse"}, {31'd0, if_done}, 32'd0);
    $display("fetch %s addr=0x%08h data=0x%08h", tag, addr, if_data);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h13; ram[12'h101] = 8'h05; ram[12'h102] = 8'h00; ram[12'h103] = 8'h00;
    ram[12'h104] = 8'h11; ram[12'h105] = 8'h22; ram[12'h106] = 8'h33; ram[12'h107] = 8'h44;
    ram[12'h200] = 8'hD4; ram[12'h201] = 8'hC3; ram[12'h202] = 8'hB2; ram[12'h203] = 8'hA1;
    ram[12'h003] = 8'h80; ram[12'hFFF] = 8'hFF; ram[12'h000] = 8'h5A;

    rst = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = '0; mem_wdata = '0;
`ifdef IF_FLUSH_EN
    if_flush = 1'b0;
`endif
    tick(); tick();
    chk("rst_ram_a", ram_a, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
    chk("rst_if_data", if_data, 32'd0);
    chk("rst_mem_rdata", mem_rdata, 32'd0);
    chk("rst_if_done", {31'd0, if_done}, 32'd0);
    chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
    $display("reset state checked");
    rst = 1'b0;
    tick();

    run_fetch(32'h100, 32'h0000_0513, "fetch100");

    // Simultaneous requests: the store goes first.
    if_req = 1'b1; if_addr = 32'h100;
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
    wword = 32'hDEAD_BEEF;
    for (int m = 1; m <= 4; m++) begin
      tick();
      chk("st_wr", {31'd0, ram_wr}, 32'd1);
      chk("st_addr", ram_a, 32'h20 + 32'(m - 1));
      chk("st_byte", {24'd0, ram_dout}, {24'd0, wword[8*(m-1) +: 8]});
      chk("st_stall_if", {31'd0, stall_req_if}, 32'd1);
      $display("store beat %0d a=0x%08h d=0x%02h wr=%0b", m - 1, ram_a, ram_dout, ram_wr);
    end
    tick();
    chk("st_done", {31'd0, mem_done}, 32'd1);
    chk("st_wr_off", {31'd0, ram_wr}, 32'd0);
    chk("st_stall_mem_low", {31'd0, stall_req_mem}, 32'd0);
    chk("st_stall_if_hold", {31'd0, stall_req_if}, 32'd1);
    mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk("st_done_pulse", {31'd0, mem_done}, 32'd0);
    chk("st_if_wait", {31'd0, stall_req_if}, 32'd1);
    tick();
    chk("post_st_fetch_a", ram_a, 32'h100);
    for (int m = 8; m <= 12; m++) begin
      tick();
      if (m == 11) chk("post_st_early", {31'd0, if_done}, 32'd0);
    end
    chk("post_st_done", {31'd0, if_done}, 32'd1);
    chk("post_st_data", if_data, 32'h0000_0513);
    if_req = 1'b0;
    tick();
    $display("store+fetch arbitration checked");

    // Byte load, zero-extended.
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h1003;
    tick();
    chk("ldb_addr", ram_a, 32'h1003);
    chk("ldb_no_wr", {31'd0, ram_wr}, 32'd0);
    tick();
    chk("ldb_early", {31'd0, mem_done}, 32'd0);
    tick();
    chk("ldb_done", {31'd0, mem_done}, 32'd1);
    chk("ldb_data", mem_rdata, 32'h0000_0080);
    mem_req = 1'b0;
    tick();
    $display("load byte addr=0x00001003 data=0x%08h", mem_rdata);

    // Half load across the top of the address space.
    mem_req = 1'b1; mem_len = 2'd1; mem_addr = 32'hFFFF_FFFF;
    tick();
    chk("ldh_addr0", ram_a, 32'hFFFF_FFFF);
    tick();
    chk("ldh_addr1_wrap", ram_a, 32'h0000_0000);
    tick();
    chk("ldh_early", {31'd0, mem_done}, 32'd0);
    tick();
    chk("ldh_done", {31'd0, mem_done}, 32'd1);
    chk("ldh_data", mem_rdata, 32'h0000_5AFF);
    mem_req = 1'b0;
    tick();
    $display("load half addr=0xffffffff data=0x%08h", mem_rdata);

    // Length code 2 behaves as a word.
    mem_req = 1'b1; mem_len = 2'd2; mem_addr = 32'h104;
    for (int m = 1; m <= 6; m++) tick();
    chk("ld2_done", {31'd0, mem_done}, 32'd1);
    chk("ld2_data", mem_rdata, 32'h4433_2211);
    mem_req = 1'b0;
    tick();
    $display("load len2 addr=0x00000104 data=0x%08h", mem_rdata);

    // Load arriving mid-fetch waits for the fetch.
    if_req = 1'b1; if_addr = 32'h104;
    tick();
    tick();
    chk("mid_beat1", ram_a, 32'h105);
    mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'd0; mem_addr = 32'h105;
    for (int m = 3; m <= 6; m++) tick();
    chk("mid_if_done", {31'd0, if_done}, 32'd1);
    chk("mid_if_data", if_data, 32'h4433_2211);
    chk("mid_no_mem_done", {31'd0, mem_done}, 32'd0);
    chk("mid_stall_mem", {31'd0, stall_req_mem}, 32'd1);
    if_req = 1'b0;
    tick();
    chk("mid_bubble_a", ram_a, 32'h107);
    tick();
    chk("mid_ld_grant_a", ram_a, 32'h105);
    tick();
    tick();
    chk("mid_ld_done", {31'd0, mem_done}, 32'd1);
    chk("mid_ld_data", mem_rdata, 32'h0000_0022);
    mem_req = 1'b0;
    tick();
    $display("fetch then load data=0x%08h", mem_rdata);

    // Reset during store beat 2.
    mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h40; mem_wdata = 32'h1122_3344;
    tick();
    tick();
    tick();
    chk("rstw_beat2_a", ram_a, 32'h42);
    chk("rstw_beat2_d", {24'd0, ram_dout}, 32'h22);
    rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
    tick();
    chk("rstw_wr_off", {31'd0, ram_wr}, 32'd0);
    chk("rstw_no_done", {31'd0, mem_done}, 32'd0);
    chk("rstw_ram_a", ram_a, 32'd0);
    chk("rstw_if_data", if_data, 32'd0);
    rst = 1'b0;
    tick();
    chk("rstw_no_done2", {31'd0, mem_done}, 32'd0);
    $display("reset mid store checked");
    run_fetch(32'h100, 32'h0000_0513, "fetch_after_rst");

`ifdef IF_FLUSH_EN
    // Flush at fetch beat 2, then a new fetch from the redirect target.
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    tick();
    tick();
    chk("fl_beat2", ram_a, 32'h102);
    if_flush = 1'b1; if_addr = 32'h200;
    tick();
    chk("fl_no_done", {31'd0, if_done}, 32'd0);
    if_flush = 1'b0;
    tick();
    chk("fl_new_a", ram_a, 32'h200);
    for (int m = 6; m <= 10; m++) begin
      tick();
      if (m == 9) chk("fl_early", {31'd0, if_done}, 32'd0);
    end
    chk("fl_done", {31'd0, if_done}, 32'd1);
    chk("fl_data", if_data, 32'hA1B2_C3D4);
    if_req = 1'b0;
    tick();
    $display("flush then fetch data=0x%08h", if_data);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Arbitrates the single byte-wide RAM port between instruction fetch (IF) and the load/store stage (MEM). Sequences each request as 1, 2 or 4 byte beats and assembles little-endian read data. Raises per-stage stall requests to ctrl, which turns them into the `stall` bus consumed by the pipeline registers (if_id, id_ex, ex_mem, …).

Parameters:
ADDR_W, 32, width of request and RAM addresses
RAM_RD_LAT, 1, RAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high (`RstEnable`)
if_req  in  1  fetch request, held until if_done
if_addr  in  ADDR_W  fetch address (word, 4 bytes)
if_data  out  32  fetched instruction
if_done  out  1  one-cycle completion pulse
mem_req  in  1  load/store request, held until mem_done
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  beats minus one: 0 = byte, 1 = half, 3 = word (2 illegal, treated as 3)
mem_addr  in  ADDR_W  data address
mem_wdata  in  32  store data
mem_rdata  out  32  raw load data, zero-extended; sign extension done in MEM stage
mem_done  out  1  one-cycle completion pulse
ram_a  out  ADDR_W  RAM byte address
ram_dout  out  8  RAM write byte
ram_wr  out  1  1 = write, 0 = read
ram_din  in  8  RAM read byte
stall_req_if  out  1  IF must hold
stall_req_mem  out  1  MEM must hold

Behaviour:
- Reset: state IDLE, ram_a=0, ram_dout=0, ram_wr=0, if_data=0, mem_rdata=0, if_done=0, mem_done=0, beat counters=0. Reset taken in any state, aborting the current transfer; no done pulse is issued.
- States: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE grant: mem_req beats if_req (older instruction wins). mem_we selects MEM_WR or MEM_RD. if_req alone selects IF_RD. Grant is registered and the first beat address drives ram_a in the next cycle.
- A granted transfer is never preempted. Requests arriving mid-transfer wait. Back-to-back: the cycle after a done pulse, the FSM is IDLE and re-arbitrates.
- Read beat i (0..N-1): ram_a = addr+i. Byte i is captured RAM_RD_LAT cycles later into bits [8i+7:8i]. After the last byte is captured: data register updated, done=1 for one cycle, return to IDLE. Word read latency from grant is 4+RAM_RD_LAT cycles.
- Write beat i: ram_a = addr+i, ram_dout = wdata[8i+7:8i], ram_wr=1. mem_done pulses in the cycle after the last beat. Word store takes 4 cycles from grant.
- ram_wr=0 in every cycle that is not a write beat. ram_a holds its last value when idle.
- Address arithmetic wraps modulo 2^ADDR_W.
- if_data and mem_rdata hold their value until the next completion of the same kind.
- stall_req_if = if_req & ~if_done. stall_req_mem = mem_req & ~mem_done. Both are combinational from the registered done.
- Requester drops req in the cycle after done. Req deasserted mid-transfer is ignored (transfer completes).

Optional Feature:
IF_FLUSH_EN: adds input if_flush (1 bit; branch redirect from EX).
- When defined: if_flush=1 while in IF_RD aborts the fetch. Next state is IDLE, no if_done, and in-flight read bytes are discarded. if_flush in any other state has no effect. A simultaneous if_flush and final capture yields no if_done.
- When not defined: the port is absent and fetches always complete.

Decomposition:
Shared defines file gets:
- state encodings ARB_IDLE/ARB_IF_RD/ARB_MEM_RD/ARB_MEM_WR;
- MEM_LEN_BYTE/HALF/WORD;
- MemAddrBus/ByteBus width macros.

Sub-module rd_pipe holds the RAM_RD_LAT-deep (valid, beat index) shift register that steers ram_din into the assembly register.

Test Plan:
- Reset mid MEM_WR beat 2 → next cycle ram_wr=0, state IDLE, no mem_done. Subsequent if_req served normally.
- if_req, if_addr=0x100, RAM bytes 13,05,00,00 → if_done at grant+5 (RAM_RD_LAT=1), if_data=0x00000513, stall_req_if low the same cycle.
- if_req and mem_req (store word 0xDEADBEEF @0x20) same cycle → store first: writes EF,BE,AD,DE to 0x20..0x23 with ram_wr=1. mem_done, then fetch granted, stall_req_if high throughout.
- Load byte @0x1003 with RAM value 0x80 → mem_rdata=0x00000080 after 1+RAM_RD_LAT cycles. Half load @0xFFFFFFFF reads 0xFFFFFFFF then 0x0 (wrap).
- mem_req arrives at IF_RD beat 1 → fetch completes unchanged, then load granted the cycle after if_done.
- IF_FLUSH_EN: if_flush at fetch beat 2 → no if_done, IDLE next cycle. New if_req @0x200 returns correct word.
